pipe_stage_reg: RTL and testbench

- Parametrised, handshaked pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces bare write-enable registers with a valid/ready interface and a 2-entry skid buffer.
- Stalls propagate without combinational ready paths, and full throughput is sustained.
- Adds synchronous flush (branch/exception squash) and occupancy visibility for hazard logic.

---
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - handshaked pipeline stage register with a 2-entry skid buffer
// Optional stall-cycle counter output enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  // Encodings double as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state_nxt = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_nxt = TWO;
          else if (!in_fire && out_fire) state_nxt = EMPTY;
        end
        TWO:     if (out_fire) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Handshake outputs are flops loaded from the next state, so out_ready never reaches in_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != TWO);
      occupancy <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else if (flush) begin
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      case (state)
        EMPTY: if (in_fire) main_q <= in_data;
        ONE: begin
          if (in_fire && out_fire) main_q <= in_data;
          else if (in_fire)        skid_q <= in_data;
        end
        TWO:     if (out_fire) main_q <= skid_q;
        default: ;
      endcase
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - random and directed bench for pipe_stage_reg against a queue model
module tb_pipe_stage_reg;
  localparam int                DW = 32;
  localparam logic [DW-1:0]     RV = 32'hDEAD_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  pipe_stage_reg #(.DATA_W(DW), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a FIFO of held payloads plus the value left in the head slot when empty.
  logic [DW-1:0] q[$];
  logic [DW-1:0] idle_val;
  logic [15:0]   m_stall;
  bit            m_in_fire, m_out_fire;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      idle_val = RV;
      m_stall  = 16'd0;
    end else begin
      m_in_fire  = in_valid && (q.size() < 2);
      m_out_fire = out_ready && (q.size() != 0);
      if ((q.size() != 0) && !out_ready && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
      if (flush) begin
        q.delete();
        idle_val = RV;
      end else begin
        if (m_out_fire) idle_val = q.pop_front();
        if (m_in_fire)  q.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("model_in_ready",  64'(in_ready),  64'(q.size() < 2));
      chk("model_occupancy", 64'(occupancy), 64'(q.size()));
      chk("model_out_data",  64'(out_data),  64'((q.size() != 0) ? q[0] : idle_val));
`ifdef PIPE_STAGE_STALL_CNT_EN
      chk("model_stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    end
  end

  // Inputs are applied just after a falling edge; returns at the next falling edge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'(RV));

    cyc(1, 32'hA, 1, 0);
    chk("stream_a", 64'(out_data), 64'hA);
    cyc(1, 32'hB, 1, 0);
    chk("stream_b", 64'(out_data), 64'hB);
    chk("stream_occ", 64'(occupancy), 64'd1);
    cyc(1, 32'hC, 1, 0);
    chk("stream_c", 64'(out_data), 64'hC);
    chk("stream_valid", 64'(out_valid), 64'd1);
    cyc(0, 32'h0, 1, 0);
    chk("stream_drained", 64'(occupancy), 64'd0);

    cyc(1, 32'h11, 0, 0);
    cyc(1, 32'h22, 0, 0);
    chk("skid_occ2",  64'(occupancy), 64'd2);
    chk("skid_ready", 64'(in_ready),  64'd0);
    chk("skid_head",  64'(out_data),  64'h11);
    cyc(0, 32'h0, 1, 0);
    chk("skid_second",   64'(out_data), 64'h22);
    chk("skid_ready_up", 64'(in_ready), 64'd1);
    cyc(0, 32'h0, 1, 0);
    chk("skid_empty", 64'(out_valid), 64'd0);

    cyc(1, 32'h11, 0, 0);
    cyc(1, 32'h22, 0, 0);
    cyc(1, 32'h33, 0, 1);
    chk("flush_occ",   64'(occupancy), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_data",  64'(out_data),  64'(RV));
    cyc(0, 32'h0, 1, 0);
    chk("flush_no_33", 64'(out_valid), 64'd0);

    cyc(1, 32'h44, 0, 0);
    chk("pre_async_occ", 64'(occupancy), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_in_ready",  64'(in_ready),  64'd1);
    chk("async_occ",       64'(occupancy), 64'd0);
    chk("async_data",      64'(out_data),  64'(RV));
    @(negedge clk);
    reset = 1'b0;

    cyc(1, 32'h55, 0, 0);
    repeat (5) cyc(0, 32'h0, 0, 0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall_five", 64'(stall_cnt), 64'd5);
`endif
    cyc(0, 32'h0, 1, 1);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall_after_flush", 64'(stall_cnt), 64'd5);
`endif
    chk("stall_flush_occ", 64'(occupancy), 64'd0);

    for (int i = 0; i < 600; i++) begin
      bit v, r, f;
      v = ($urandom_range(0, 3) != 0);
      r = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 29) == 0);
      cyc(v, v ? DW'($urandom) : 'x, r, f);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
